disp_ch_sched: RTL and testbench

Channel scheduler and write arbiter for the 8-channel 32-bit seven-segment display multiplexer. Shares the multiplexer's channel-0 load port (enable strobe, 32-bit data, low blink/point bytes) among four requesters with round-robin arbitration and a two-phase grant/strobe handshake. Also drives the multiplexer's 3-bit channel select, either from switches or by auto-scanning all eight channels with a programmable dwell. Sits between the CPU/peripheral masters and the display multiplexer in the top level.

---
 rtl/disp_ch_sched.sv | 106 ++++++++++
 tb/tb_disp_ch_sched.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_ch_sched.sv
// Channel scheduler for the seven-segment multiplexer: round-robin
// write arbitration onto the channel-0 load port plus channel select.
module disp_ch_sched #(
    parameter int unsigned DWELL = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [127:0] wdata,
    input  logic [31:0]  wles,
    input  logic [31:0]  wpoint,
    input  logic         mode,
    input  logic [2:0]   sw_sel,
    input  logic         follow,
    output logic [3:0]   gnt,
    output logic         EN,
    output logic [31:0]  Data0,
    output logic [7:0]   LES_lo,
    output logic [7:0]   point_lo,
    output logic [2:0]   Test,
    output logic         busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;

    localparam logic [25:0] DW_LAST = 26'(DWELL - 1);

    logic [1:0]  state;
    logic [1:0]  last;
    logic [1:0]  win;
    logic [1:0]  idx;
    logic [25:0] cnt;

    // Walk from lowest to highest priority so the nearest hit after last wins.
    always_comb begin
        win = 2'd0;
        idx = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = last + k[1:0];
            if (req[idx]) win = idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last     <= 2'd3;
            gnt      <= 4'b0000;
            EN       <= 1'b0;
            busy     <= 1'b0;
            Data0    <= 32'hAA5555AA;
            LES_lo   <= 8'hFF;
            point_lo <= 8'h00;
        end else begin
            gnt <= 4'b0000;
            EN  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        gnt      <= 4'b0001 << win;
                        last     <= win;
                        Data0    <= wdata[{win, 5'b0} +: 32];
                        LES_lo   <= wles[{win, 3'b0} +: 8];
                        point_lo <= wpoint[{win, 3'b0} +: 8];
                    end
                end
                LOAD: begin
                    state <= STROBE;
                    EN    <= 1'b1;
                end
                STROBE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A completed write with follow set snaps the display back to channel 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Test <= 3'd0;
            cnt  <= 26'd0;
        end else if (follow && state == STROBE) begin
            Test <= 3'd0;
            cnt  <= 26'd0;
        end else if (!mode) begin
            Test <= sw_sel;
            cnt  <= 26'd0;
        end else if (cnt == DW_LAST) begin
            Test <= Test + 3'd1;
            cnt  <= 26'd0;
        end else begin
            cnt <= cnt + 26'd1;
        end
    end

endmodule

// File: tb/tb_disp_ch_sched.sv
// Bench for disp_ch_sched: transaction scoreboard plus cycle model of
// arbitration, handshake and channel scan, with directed and random phases.
module tb_disp_ch_sched;

    localparam int DW = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   req = 4'b0;
    logic [127:0] wdata = '0;
    logic [31:0]  wles = '0;
    logic [31:0]  wpoint = '0;
    logic         mode = 1'b0;
    logic [2:0]   sw_sel = 3'd0;
    logic         follow = 1'b0;
    logic [3:0]   gnt;
    logic         EN;
    logic [31:0]  Data0;
    logic [7:0]   LES_lo;
    logic [7:0]   point_lo;
    logic [2:0]   Test;
    logic         busy;

    int n_pass = 0;
    int n_total = 0;
    int wait_c[4];

    typedef struct {
        int          w;
        logic [31:0] d;
        logic [7:0]  l;
        logic [7:0]  p;
    } txn_t;

    txn_t exp_q[$];

    // reference model state
    int          m_phase;
    int          m_last;
    int          m_elapsed;
    int          m_test;
    logic [3:0]  m_gnt;
    logic        m_en;
    logic        m_busy;
    logic [31:0] m_data;
    logic [7:0]  m_les;
    logic [7:0]  m_pt;

    always #5 clk = ~clk;

    disp_ch_sched #(.DWELL(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .wles(wles),
        .wpoint(wpoint), .mode(mode), .sw_sel(sw_sel), .follow(follow),
        .gnt(gnt), .EN(EN), .Data0(Data0), .LES_lo(LES_lo),
        .point_lo(point_lo), .Test(Test), .busy(busy)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int oh_idx(logic [3:0] g);
        for (int i = 0; i < 4; i++)
            if (g == 4'(1 << i)) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_last = 3; m_elapsed = 0; m_test = 0;
        m_gnt = 4'b0; m_en = 1'b0; m_busy = 1'b0;
        m_data = 32'hAA5555AA; m_les = 8'hFF; m_pt = 8'h00;
        exp_q.delete();
    endtask

    // m_phase: cycles of the handshake still to run (2 = grant cycle, 1 = strobe)
    task automatic model_step();
        int   old;
        int   w;
        txn_t t;
        old = m_phase;
        m_gnt = 4'b0;
        m_en = (old == 2);
        if (old == 0 && req != 4'b0) begin
            w = -1;
            for (int k = 1; k <= 4; k++)
                if (w < 0 && (req & 4'(1 << ((m_last + k) % 4))) != 0)
                    w = (m_last + k) % 4;
            m_gnt = 4'(1 << w);
            m_last = w;
            m_data = 32'(wdata >> (32 * w));
            m_les = 8'(wles >> (8 * w));
            m_pt = 8'(wpoint >> (8 * w));
            t.w = w; t.d = m_data; t.l = m_les; t.p = m_pt;
            exp_q.push_back(t);
            m_phase = 2;
        end else if (old > 0) begin
            m_phase = old - 1;
        end
        m_busy = (m_phase != 0);
        if (follow && old == 1) begin
            m_test = 0; m_elapsed = 0;
        end else if (!mode) begin
            m_test = int'(sw_sel); m_elapsed = 0;
        end else begin
            m_elapsed++;
            if (m_elapsed == DW) begin
                m_elapsed = 0;
                m_test = (m_test + 1) % 8;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // monitor: per-cycle outputs and write transactions
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            chk("gnt", 32'(gnt), 32'(m_gnt));
            chk("en", 32'(EN), 32'(m_en));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("test", 32'(Test), 32'(m_test));
            chk("data0", Data0, m_data);
            chk("les_lo", 32'(LES_lo), 32'(m_les));
            chk("point_lo", 32'(point_lo), 32'(m_pt));
            if (gnt !== 4'b0) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL txn: grant %b, want no write pending", gnt);
                end else begin
                    t = exp_q.pop_front();
                    chk("txn_gnt", 32'(gnt), 32'd1 << t.w);
                    chk("txn_data", Data0, t.d);
                    chk("txn_les", 32'(LES_lo), 32'(t.l));
                    chk("txn_pt", 32'(point_lo), 32'(t.p));
                end
            end
        end
    end

    task automatic step(output logic [3:0] g);
        logic [3:0] m;
        @(negedge clk);
        g = gnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            m = 4'(1 << i);
            if ((g & m) != 0) begin
                req = req & ~m;
                wait_c[i] = 0;
            end else if ((req & m) != 0) begin
                wait_c[i]++;
                if (wait_c[i] > 40) begin
                    n_total++;
                    $display("FAIL req_timeout: req %0d waited %0d, want <= 40", i, wait_c[i]);
                    req = req & ~m;
                    wait_c[i] = 0;
                end
            end
        end
    endtask

    task automatic steps(int n);
        logic [3:0] g;
        repeat (n) step(g);
    endtask

    task automatic raise(int i, logic [31:0] d, logic [7:0] l, logic [7:0] p);
        wdata = (wdata & ~(128'hFFFFFFFF << (32 * i))) | (128'(d) << (32 * i));
        wles = (wles & ~(32'hFF << (8 * i))) | (32'(l) << (8 * i));
        wpoint = (wpoint & ~(32'hFF << (8 * i))) | (32'(p) << (8 * i));
        req = req | 4'(1 << i);
        wait_c[i] = 0;
    endtask

    initial begin
        logic [3:0] g;
        int order[$];
        int n;
        bit got2;

        for (int i = 0; i < 4; i++) wait_c[i] = 0;

        // reset held with random inputs
        repeat (5) begin
            @(posedge clk); #1;
            req = 4'($urandom);
            wdata = {$urandom, $urandom, $urandom, $urandom};
            wles = $urandom; wpoint = $urandom;
            mode = 1'($urandom); sw_sel = 3'($urandom); follow = 1'($urandom);
        end
        chk("rst_data0", Data0, 32'hAA5555AA);
        chk("rst_les", 32'(LES_lo), 32'hFF);
        chk("rst_pt", 32'(point_lo), 32'h00);
        chk("rst_test", 32'(Test), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_en", 32'(EN), 32'd0);
        req = 4'b0; mode = 1'b0; sw_sel = 3'd0; follow = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        steps(4);
        chk("no_spur_busy", 32'(busy), 32'd0);

        // round robin with all four requesting
        for (int i = 0; i < 4; i++) raise(i, $urandom, 8'($urandom), 8'($urandom));
        order.delete();
        repeat (13) begin
            step(g);
            if (g != 4'b0) order.push_back(oh_idx(g));
        end
        chk("rr_count", 32'(order.size()), 32'd4);
        for (int k = 0; k < order.size(); k++)
            chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'(k));

        // 1001 after last=3: 0 then 3
        raise(0, $urandom, 8'($urandom), 8'($urandom));
        raise(3, $urandom, 8'($urandom), 8'($urandom));
        order.delete();
        repeat (8) begin
            step(g);
            if (g != 4'b0) order.push_back(oh_idx(g));
        end
        chk("rr9_count", 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            chk("rr9_first", 32'(order[0]), 32'd0);
            chk("rr9_second", 32'(order[1]), 32'd3);
        end

        // single write from requester 1
        raise(1, 32'h12345678, 8'h0F, 8'h5A);
        step(g);
        chk("sw_gnt", 32'(gnt), 32'b0010);
        chk("sw_data", Data0, 32'h12345678);
        chk("sw_les", 32'(LES_lo), 32'h0F);
        chk("sw_en_load", 32'(EN), 32'd0);
        step(g);
        chk("sw_en", 32'(EN), 32'd1);
        chk("sw_gnt_strobe", 32'(gnt), 32'd0);
        steps(2);

        // auto-scan from channel 6
        sw_sel = 3'd6;
        steps(1);
        chk("scan_start", 32'(Test), 32'd6);
        mode = 1'b1;
        steps(3);
        chk("scan_hold", 32'(Test), 32'd6);
        steps(1);
        chk("scan_7", 32'(Test), 32'd7);
        steps(4);
        chk("scan_0", 32'(Test), 32'd0);
        steps(4);
        chk("scan_1", 32'(Test), 32'd1);
        mode = 1'b0; sw_sel = 3'd5;
        steps(1);
        chk("manual_5", 32'(Test), 32'd5);

        // follow strobe colliding with dwell expiry at channel 3
        sw_sel = 3'd2;
        steps(1);
        mode = 1'b1;
        steps(5);
        chk("fol_pre", 32'(Test), 32'd3);
        follow = 1'b1;
        raise(0, $urandom, 8'($urandom), 8'($urandom));
        steps(2);
        chk("fol_en", 32'(EN), 32'd1);
        steps(1);
        chk("fol_zero", 32'(Test), 32'd0);
        steps(3);
        chk("fol_hold", 32'(Test), 32'd0);
        steps(1);
        chk("fol_next", 32'(Test), 32'd1);
        follow = 1'b0; mode = 1'b0;
        steps(3);

        // reset during LOAD
        raise(2, 32'hCAFEF00D, 8'h3C, 8'hC3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt[2] !== 1'b1 && n < 10);
        if (gnt[2] !== 1'b1) begin
            n_total++;
            $display("FAIL mid_wait: gnt %b after %0d cycles, want gnt[2]", gnt, n);
        end
        #2 rst = 1'b0;
        #1;
        chk("mid_gnt", 32'(gnt), 32'd0);
        chk("mid_en", 32'(EN), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_data", Data0, 32'hAA5555AA);
        @(posedge clk); #1;
        rst = 1'b1;
        got2 = 1'b0;
        repeat (6) begin
            step(g);
            if (g == 4'b0100) got2 = 1'b1;
        end
        chk("mid_regrant", 32'(got2), 32'd1);
        chk("mid_redata", Data0, 32'hCAFEF00D);

        // random traffic
        repeat (400) begin
            for (int i = 0; i < 4; i++)
                if ((req & 4'(1 << i)) == 0 && $urandom_range(3) == 0)
                    raise(i, $urandom, 8'($urandom), 8'($urandom));
            if ($urandom_range(15) == 0) mode = ~mode;
            sw_sel = 3'($urandom);
            follow = ($urandom_range(3) == 0);
            rst = ($urandom_range(149) != 0);
            step(g);
        end
        rst = 1'b1;
        req = 4'b0;
        steps(6);
        chk("q_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
